trap_sequencer: RTL and testbench

Parametrised micro-op injector that replaces the single-purpose RTI sequencer. It supports two modes. RTI mode pops PC-high, PC-low and CCR. INT mode pushes CCR, PC-low and PC-high, then requests a vector load. In both modes a configurable number of NOP drain cycles follows, and fetch is stalled for the whole sequence. The block sits between fetch and decode: while busy, its `out` word replaces the fetched instruction.

---
 rtl/trap_sequencer.sv | 143 ++++++++++++++
 tb/tb_trap_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap micro-op injector: RTI pops or INT pushes, then NOP drain.
// Sits between fetch and decode; out replaces the fetched word while busy.
module trap_sequencer #(
  parameter int INSTR_W = 16,
  parameter int NOP_CYCLES = 4,
  parameter logic [INSTR_W-1:0] POP_PC_HIGH_OP  = 16'b0110000010001001,
  parameter logic [INSTR_W-1:0] POP_PC_LOW_OP   = 16'b0110000010001000,
  parameter logic [INSTR_W-1:0] POP_CCR_OP      = 16'hFFFF,
  parameter logic [INSTR_W-1:0] PUSH_CCR_OP     = 16'hFFFE,
  parameter logic [INSTR_W-1:0] PUSH_PC_LOW_OP  = 16'b0101000010001000,
  parameter logic [INSTR_W-1:0] PUSH_PC_HIGH_OP = 16'b0101000010001001,
  parameter logic [INSTR_W-1:0] NOP_OP          = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rti,
  input  logic               intr,
  input  logic               hold,
  output logic [INSTR_W-1:0] out,
  output logic               out_valid,
  output logic               stall,
  output logic               busy,
  output logic               mode,
  output logic               done,
  output logic               vec_load
);

  localparam int CW = (NOP_CYCLES < 1) ? 1 : $clog2(NOP_CYCLES + 1);
  localparam logic [CW-1:0] NOP_N = CW'(NOP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_OP0, S_OP1, S_OP2, S_DRAIN
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_int_q, pend_int_d;
  logic pend_rti_q, pend_rti_d;
  logic mode_q, mode_d;
  logic [INSTR_W-1:0] out_q, out_d;
  logic ov_q, ov_d;
  logic stall_q, stall_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic vl_q, vl_d;
  logic want_int, want_rti;

  assign want_int = intr | pend_int_q;
  assign want_rti = rti | pend_rti_q;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pend_int_d = pend_int_q | intr;
    pend_rti_d = pend_rti_q | rti;
    mode_d = mode_q;
    out_d = out_q;
    ov_d = ov_q;
    stall_d = stall_q;
    busy_d = busy_q;
    done_d = done_q;
    vl_d = vl_q;
    if (!hold) begin
      unique case (state_q)
        S_IDLE: begin
          if (want_int) begin
            state_d = S_OP0;
            mode_d = 1'b1;
            pend_int_d = 1'b0;
          end else if (want_rti) begin
            state_d = S_OP0;
            mode_d = 1'b0;
            pend_rti_d = 1'b0;
          end
        end
        S_OP0: state_d = S_OP1;
        S_OP1: state_d = S_OP2;
        S_OP2: begin
          if (NOP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
            cnt_d = NOP_N;
          end
        end
        S_DRAIN: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      // Outputs are registered from the next state
      busy_d = (state_d != S_IDLE);
      ov_d = busy_d;
      stall_d = busy_d | pend_int_d | pend_rti_d;
      done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
      vl_d = done_d & mode_d;
      unique case (state_d)
        S_OP0: out_d = mode_d ? PUSH_CCR_OP : POP_PC_HIGH_OP;
        S_OP1: out_d = mode_d ? PUSH_PC_LOW_OP : POP_PC_LOW_OP;
        S_OP2: out_d = mode_d ? PUSH_PC_HIGH_OP : POP_CCR_OP;
        default: out_d = NOP_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      pend_int_q <= 1'b0;
      pend_rti_q <= 1'b0;
      mode_q <= 1'b0;
      out_q <= NOP_OP;
      ov_q <= 1'b0;
      stall_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      vl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_int_q <= pend_int_d;
      pend_rti_q <= pend_rti_d;
      mode_q <= mode_d;
      out_q <= out_d;
      ov_q <= ov_d;
      stall_q <= stall_d;
      busy_q <= busy_d;
      done_q <= done_d;
      vl_q <= vl_d;
    end
  end

  assign out = out_q;
  assign out_valid = ov_q;
  assign stall = stall_q;
  assign busy = busy_q;
  assign mode = mode_q;
  assign done = done_q;
  assign vec_load = vl_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: two builds (4 and 0 drain NOPs)
// checked each cycle against a position-counter reference model.
module tb_trap_sequencer;

  logic clk = 1'b0;
  logic reset, rti, intr, hold;

  logic [15:0] out4, out0;
  logic ov4, st4, bz4, md4, dn4, vl4;
  logic ov0, st0, bz0, md0, dn0, vl0;

  int total = 0;
  int bad = 0;

  int pos [2];
  bit pi [2];
  bit pr [2];
  bit mdl [2];
  logic [21:0] ev [2];

  int sc4, sc0, dc4, dc0, vc4, n5088;

  always #5 clk = ~clk;

  trap_sequencer #(.NOP_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset), .rti(rti), .intr(intr), .hold(hold),
    .out(out4), .out_valid(ov4), .stall(st4), .busy(bz4),
    .mode(md4), .done(dn4), .vec_load(vl4)
  );

  trap_sequencer #(.NOP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .rti(rti), .intr(intr), .hold(hold),
    .out(out0), .out_valid(ov0), .stall(st0), .busy(bz0),
    .mode(md0), .done(dn0), .vec_load(vl0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word(input bit m, input int p);
    case (p)
      1: return m ? 16'hFFFE : 16'h6089;
      2: return m ? 16'h5088 : 16'h6088;
      3: return m ? 16'h5089 : 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  // Position 0 is idle; 1..3 are the ops; 4..3+n are the drain NOPs.
  task automatic model_step(input int k);
    int n;
    bit wi, wr, fin;
    n = (k == 0) ? 4 : 0;
    fin = 1'b0;
    if (!reset) begin
      pos[k] = 0; pi[k] = 0; pr[k] = 0; mdl[k] = 0; ev[k] = '0;
    end else if (hold) begin
      pi[k] |= intr;
      pr[k] |= rti;
    end else begin
      if (pos[k] == 0) begin
        wi = intr | pi[k];
        wr = rti | pr[k];
        if (wi) begin
          mdl[k] = 1; pi[k] = 0; pr[k] = wr; pos[k] = 1;
        end else if (wr) begin
          mdl[k] = 0; pr[k] = 0; pos[k] = 1;
        end
      end else begin
        pi[k] |= intr;
        pr[k] |= rti;
        pos[k]++;
        if (pos[k] > 3 + n) begin
          pos[k] = 0;
          fin = 1'b1;
        end
      end
      if (pos[k] > 0)
        ev[k] = {word(mdl[k], pos[k]), 3'b111, mdl[k], 2'b00};
      else
        ev[k] = {16'h0000, 1'b0, pi[k] | pr[k], 1'b0, mdl[k],
                 fin, fin & mdl[k]};
    end
  endtask

  task automatic cyc(input bit r, input bit i, input bit h, input bit rs);
    rti = r; intr = i; hold = h; reset = rs;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    chk("n4", {10'd0, out4, ov4, st4, bz4, md4, dn4, vl4}, {10'd0, ev[0]});
    chk("n0", {10'd0, out0, ov0, st0, bz0, md0, dn0, vl0}, {10'd0, ev[1]});
    sc4 += int'(st4); sc0 += int'(st0);
    dc4 += int'(dn4); dc0 += int'(dn0);
    vc4 += int'(vl4);
    n5088 += int'(out4 == 16'h5088);
  endtask

  task automatic clr();
    sc4 = 0; sc0 = 0; dc4 = 0; dc0 = 0; vc4 = 0; n5088 = 0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cyc(0, 0, 0, 1);
  endtask

  initial begin
    clr();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rst_out", {16'd0, out4}, 32'h0);
    chk("rst_flags", {26'd0, ov4, st4, bz4, md4, dn4, vl4}, 32'h0);
    idle(2);

    clr();
    cyc(1, 0, 0, 1);
    chk("rti_op0", {16'd0, out4}, 32'h6089);
    idle(9);
    chk("rti_stall", sc4, 7);
    chk("rti_done", dc4, 1);
    chk("rti_vl", vc4, 0);
    chk("n0_stall", sc0, 3);
    chk("n0_done", dc0, 1);

    clr();
    cyc(0, 1, 0, 1);
    chk("int_op0", {16'd0, out4}, 32'hFFFE);
    chk("int_mode", {31'd0, md4}, 32'h1);
    idle(9);
    chk("int_stall", sc4, 7);
    chk("int_done", dc4, 1);
    chk("int_vl", vc4, 1);

    clr();
    cyc(1, 1, 0, 1);
    idle(20);
    chk("both_done", dc4, 2);
    chk("both_stall", sc4, 15);
    chk("both_vl", vc4, 1);

    clr();
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    chk("hold_op2", {16'd0, out4}, 32'h5089);
    chk("hold_cnt", n5088, 4);
    idle(20);
    chk("hold_done", dc4, 2);

    clr();
    cyc(1, 0, 0, 1);
    idle(3);
    cyc(0, 0, 0, 0);
    chk("mid_rst", {26'd0, ov4, st4, bz4, md4, dn4, vl4}, 32'h0);
    idle(3);
    chk("mid_nodone", dc4, 0);
    cyc(1, 0, 0, 1);
    chk("mid_restart", {16'd0, out4}, 32'h6089);
    idle(9);
    chk("mid_done", dc4, 1);

    for (int c = 0; c < 500; c++)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 59) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
